// File: rtl/dtc_fe_pkg.sv
// Shared types for the DTC front-end ping-pong path: FSM encoding and per-state strobe schedule.
package dtc_fe_pkg;

    localparam int PKT_LEN_DEF   = 64;
    localparam int MEM_DEPTH_DEF = 1536;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        XFER_A,
        XFER_B,
        DRAIN_0,
        DRAIN_1
    } dtc_state_e;

    typedef struct packed {
        logic wr0;
        logic wr1;
        logic rd0;
        logic rd1;
        logic rd_sel;
    } dtc_sched_t;

    // Which FIFO each state fills/drains; writes here are issue-time, before BRAM latency.
    function automatic dtc_sched_t sched_of(input dtc_state_e st);
        dtc_sched_t s;
        s = '0;
        case (st)
            PRIME:   s.wr0 = 1'b1;
            XFER_A:  begin s.wr1 = 1'b1; s.rd0 = 1'b1; end
            XFER_B:  begin s.wr0 = 1'b1; s.rd1 = 1'b1; s.rd_sel = 1'b1; end
            DRAIN_0: s.rd0 = 1'b1;
            DRAIN_1: begin s.rd1 = 1'b1; s.rd_sel = 1'b1; end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dtc_wr_delay.sv
// Delays the per-FIFO write schedule by the cicbram read latency so strobes line up with douta.
module dtc_wr_delay #(
    parameter int BRAM_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] sched_i,
    output logic [1:0] sched_o
);

    logic [BRAM_LAT-1:0][1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= sched_i;
            for (int i = 1; i < BRAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign sched_o = pipe_q[BRAM_LAT-1];

endmodule

// File: rtl/dtc_pingpong_ctrl.sv
// Ping-pong sequencer: steps cicbram address, alternates the two dtc_buff FIFOs per packet phase,
// qualifies strobes with full/empty and keeps sticky overflow/underflow flags.
module dtc_pingpong_ctrl
    import dtc_fe_pkg::*;
#(
    parameter int PKT_LEN   = PKT_LEN_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int ADDR_W    = 11,
    parameter int BRAM_LAT  = 1,
    parameter int CNT_W     = 16
) (
    input  logic              CLK320,
    input  logic              RST_N,
    input  logic              ENABLE,
    input  logic              CLR_ERR,
    input  logic              FULL_0,
    input  logic              EMPTY_0,
    input  logic              FULL_1,
    input  logic              EMPTY_1,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic              WR_EN_0,
    output logic              WR_EN_1,
    output logic              RD_EN_0,
    output logic              RD_EN_1,
    output logic              RD_SEL,
    output logic              PKT_START,
    output logic [CNT_W-1:0]  PKT_CNT,
    output logic              BUSY,
    output logic              OVF,
    output logic              UDF
);

    localparam int                PH_W     = $clog2(PKT_LEN);
    localparam logic [PH_W-1:0]   PH_END   = PH_W'(PKT_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(MEM_DEPTH - 1);

    dtc_state_e        state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    dtc_sched_t        nxt_s;
    logic [1:0]        wr_due;
    logic              ph_end, cur_fill, cur_read, ovf_ev, udf_ev;
    logic              wr0_q, wr1_q, rd0_q, rd1_q, sel_q, start_q, busy_q, ovf_q, udf_q;

    assign ph_end   = (ph_q == PH_END);
    assign cur_fill = state_q inside {PRIME, XFER_A, XFER_B};
    assign cur_read = state_q inside {XFER_A, XFER_B, DRAIN_0, DRAIN_1};
    assign nxt_s    = sched_of(state_d);

    // ENABLE only matters in IDLE and at phase end, so a phase always runs to completion.
    always_comb begin
        state_d = state_q;
        ph_d    = '0;
        case (state_q)
            IDLE:             if (ENABLE) state_d = PRIME;
            PRIME:            if (ph_end) state_d = XFER_A;
            XFER_A:           if (ph_end) state_d = ENABLE ? XFER_B : DRAIN_1;
            XFER_B:           if (ph_end) state_d = ENABLE ? XFER_A : DRAIN_0;
            DRAIN_0, DRAIN_1: if (ph_end) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
        if (state_q != IDLE && !ph_end) ph_d = ph_q + PH_W'(1);
    end

    always_ff @(posedge CLK320 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ph_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            if (cur_fill) addr_q <= (addr_q == ADDR_END) ? '0 : addr_q + ADDR_W'(1);
            if (ph_end && cur_read) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Tail writes keep flowing out of the delay line after the filling state has ended.
    dtc_wr_delay #(.BRAM_LAT(BRAM_LAT)) u_wr_delay (
        .clk_i   (CLK320),
        .rst_ni  (RST_N),
        .sched_i ({nxt_s.wr1, nxt_s.wr0}),
        .sched_o (wr_due)
    );

    assign ovf_ev = (wr_due[0] & FULL_0) | (wr_due[1] & FULL_1);
    assign udf_ev = (nxt_s.rd0 & EMPTY_0) | (nxt_s.rd1 & EMPTY_1);

    always_ff @(posedge CLK320 or negedge RST_N) begin
        if (!RST_N) begin
            wr0_q   <= 1'b0;
            wr1_q   <= 1'b0;
            rd0_q   <= 1'b0;
            rd1_q   <= 1'b0;
            sel_q   <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wr0_q   <= wr_due[0] & ~FULL_0;
            wr1_q   <= wr_due[1] & ~FULL_1;
            rd0_q   <= nxt_s.rd0 & ~EMPTY_0;
            rd1_q   <= nxt_s.rd1 & ~EMPTY_1;
            sel_q   <= nxt_s.rd_sel;
            start_q <= (state_d != IDLE) && (ph_d == '0);
            busy_q  <= (state_d != IDLE);
            ovf_q   <= (ovf_q & ~CLR_ERR) | ovf_ev;
            udf_q   <= (udf_q & ~CLR_ERR) | udf_ev;
        end
    end

    assign BRAM_ADDR = addr_q;
    assign WR_EN_0   = wr0_q;
    assign WR_EN_1   = wr1_q;
    assign RD_EN_0   = rd0_q;
    assign RD_EN_1   = rd1_q;
    assign RD_SEL    = sel_q;
    assign PKT_START = start_q;
    assign PKT_CNT   = cnt_q;
    assign BUSY      = busy_q;
    assign OVF       = ovf_q;
    assign UDF       = udf_q;

endmodule

// File: tb/tb_dtc_pingpong_ctrl.sv
// Directed bench for dtc_pingpong_ctrl: long run with phase-window model, then error/reset scenarios.
module tb_dtc_pingpong_ctrl;

    logic        CLK320 = 1'b0;
    logic        RST_N = 1'b0, ENABLE = 1'b0, CLR_ERR = 1'b0;
    logic        FULL_0 = 1'b0, EMPTY_0 = 1'b0, FULL_1 = 1'b0, EMPTY_1 = 1'b0;
    logic [10:0] BRAM_ADDR;
    logic        WR_EN_0, WR_EN_1, RD_EN_0, RD_EN_1, RD_SEL, PKT_START, BUSY, OVF, UDF;
    logic [15:0] PKT_CNT;

    int n_chk = 0;
    int n_fail = 0;

    localparam int RUN1 = 1680;
    logic tr_wr0 [0:RUN1];
    logic tr_wr1 [0:RUN1];
    logic tr_rd0 [0:RUN1];
    logic tr_rd1 [0:RUN1];
    logic tr_sel [0:RUN1];
    logic tr_st  [0:RUN1];

    dtc_pingpong_ctrl u_dut (
        .CLK320(CLK320), .RST_N(RST_N), .ENABLE(ENABLE), .CLR_ERR(CLR_ERR),
        .FULL_0(FULL_0), .EMPTY_0(EMPTY_0), .FULL_1(FULL_1), .EMPTY_1(EMPTY_1),
        .BRAM_ADDR(BRAM_ADDR), .WR_EN_0(WR_EN_0), .WR_EN_1(WR_EN_1),
        .RD_EN_0(RD_EN_0), .RD_EN_1(RD_EN_1), .RD_SEL(RD_SEL), .PKT_START(PKT_START),
        .PKT_CNT(PKT_CNT), .BUSY(BUSY), .OVF(OVF), .UDF(UDF)
    );

    always #5 CLK320 = ~CLK320;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK320);
        #1;
    endtask

    function automatic logic [19:0] outs();
        return {BRAM_ADDR, WR_EN_0, WR_EN_1, RD_EN_0, RD_EN_1, RD_SEL, PKT_START, BUSY, OVF, UDF};
    endfunction

    // Run 1: phase p covers cycles 64p+1..64p+64; p=0 PRIME, odd XFER_A, even XFER_B up to 24, 25 DRAIN_0.
    function automatic int ph_of(input int j);
        return (j >= 1 && j <= 1664) ? (j - 1) / 64 : -1;
    endfunction

    function automatic logic e_rd0(input int k);
        int p = ph_of(k);
        return ((p % 2 == 1) && p <= 23) || p == 25;
    endfunction

    function automatic logic e_rd1(input int k);
        int p = ph_of(k);
        return p >= 2 && (p % 2 == 0) && p <= 24;
    endfunction

    function automatic logic e_wr0(input int k);
        int p = ph_of(k - 1);
        return p == 0 || (p >= 2 && (p % 2 == 0) && p <= 24);
    endfunction

    function automatic logic e_wr1(input int k);
        int p = ph_of(k - 1);
        return (p % 2 == 1) && p <= 23;
    endfunction

    initial begin
        int bad_wr0, bad_wr1, bad_rd0, bad_rd1, bad_sel, bad_st;
        int s_wr0, s_rdpre, s_rd0, s_drain, s_wr1, s_rdu;
        bad_wr0 = 0; bad_wr1 = 0; bad_rd0 = 0; bad_rd1 = 0; bad_sel = 0; bad_st = 0;
        s_wr0 = 0; s_rdpre = 0; s_rd0 = 0; s_drain = 0; s_wr1 = 0; s_rdu = 0;

        repeat (3) tick();
        chk("rst_outs", 32'(outs()), 0);
        chk("rst_cnt", PKT_CNT, 0);
        @(negedge CLK320);
        RST_N = 1'b1;
        tick();
        chk("idle_busy", BUSY, 0);
        ENABLE = 1'b1;

        for (int k = 1; k <= RUN1; k++) begin
            tick();
            tr_wr0[k] = WR_EN_0; tr_wr1[k] = WR_EN_1; tr_rd0[k] = RD_EN_0;
            tr_rd1[k] = RD_EN_1; tr_sel[k] = RD_SEL;  tr_st[k]  = PKT_START;
            if (k == 1) begin
                chk("t1_start", PKT_START, 1);
                chk("t1_addr", BRAM_ADDR, 0);
                chk("t1_wr0", WR_EN_0, 0);
            end
            if (k == 640) chk("cnt_before_10th", PKT_CNT, 8);
            if (k == 641) begin
                chk("cnt_after_10th", PKT_CNT, 9);
                chk("ovf_steady", OVF, 0);
                chk("udf_steady", UDF, 0);
            end
            if (k == 1536) chk("addr_top", BRAM_ADDR, 1535);
            if (k == 1537) chk("addr_wrap", BRAM_ADDR, 0);
            if (k == 1560) ENABLE = 1'b0;
            if (k == 1601) chk("addr_drain", BRAM_ADDR, 64);
            if (k == 1664) chk("busy_drain_end", BUSY, 1);
            if (k == 1665) begin
                chk("busy_idle", BUSY, 0);
                chk("cnt_final", PKT_CNT, 25);
            end
            if (k == RUN1) begin
                chk("addr_hold", BRAM_ADDR, 64);
                chk("flags_run1", {OVF, UDF}, 0);
            end
        end

        for (int k = 1; k <= RUN1; k++) begin
            if (tr_wr0[k] !== e_wr0(k)) bad_wr0++;
            if (tr_wr1[k] !== e_wr1(k)) bad_wr1++;
            if (tr_rd0[k] !== e_rd0(k)) bad_rd0++;
            if (tr_rd1[k] !== e_rd1(k)) bad_rd1++;
            if (tr_sel[k] !== e_rd1(k)) bad_sel++;
            if (tr_st[k] !== (ph_of(k) >= 0 && (k - 1) % 64 == 0)) bad_st++;
            if (k >= 2 && k <= 65) s_wr0 += int'(tr_wr0[k]);
            if (k <= 64) s_rdpre += int'(tr_rd0[k]) + int'(tr_rd1[k]);
            if (k >= 65 && k <= 128) s_rd0 += int'(tr_rd0[k]);
            if (k >= 1601 && k <= 1664) s_drain += int'(tr_rd0[k]);
        end
        chk("prime_wr0_cnt", s_wr0, 64);
        chk("prime_no_reads", s_rdpre, 0);
        chk("xa1_rd0_cnt", s_rd0, 64);
        chk("drain0_rd0_cnt", s_drain, 64);
        chk("wr0_pattern_errs", bad_wr0, 0);
        chk("wr1_pattern_errs", bad_wr1, 0);
        chk("rd0_pattern_errs", bad_rd0, 0);
        chk("rd1_pattern_errs", bad_rd1, 0);
        chk("rdsel_pattern_errs", bad_sel, 0);
        chk("pktstart_pattern_errs", bad_st, 0);

        // Run 2: FIFO full/empty qualification, sticky flags, async reset mid XFER_A.
        RST_N = 1'b0;
        tick();
        @(negedge CLK320);
        RST_N = 1'b1;
        tick();
        ENABLE = 1'b1;
        for (int k = 1; k <= 121; k++) begin
            tick();
            if (k == 69) chk("xa_wr1_on", WR_EN_1, 1);
            if (k == 70) FULL_1 = 1'b1;
            if (k >= 71 && k <= 100) s_wr1 += int'(WR_EN_1);
            if (k == 72) chk("ovf_set", OVF, 1);
            if (k == 100) FULL_1 = 1'b0;
            if (k == 110) begin
                chk("ovf_sticky", OVF, 1);
                CLR_ERR = 1'b1;
            end
            if (k == 111) begin
                chk("ovf_cleared", OVF, 0);
                chk("wr1_resumed", WR_EN_1, 1);
                CLR_ERR = 1'b0;
            end
            if (k == 112) begin
                chk("rd0_before_empty", RD_EN_0, 1);
                EMPTY_0 = 1'b1;
            end
            if (k == 113) chk("udf_set", UDF, 1);
            if (k >= 113 && k <= 116) s_rdu += int'(RD_EN_0);
            if (k == 115) CLR_ERR = 1'b1;
            if (k == 116) begin
                chk("udf_set_beats_clr", UDF, 1);
                CLR_ERR = 1'b0;
                EMPTY_0 = 1'b0;
            end
            if (k == 117) chk("rd0_resumed", RD_EN_0, 1);
            if (k == 118) CLR_ERR = 1'b1;
            if (k == 119) begin
                chk("udf_cleared", UDF, 0);
                chk("ovf_quiet", OVF, 0);
                CLR_ERR = 1'b0;
            end
        end
        chk("full1_wr1_suppressed", s_wr1, 0);
        chk("empty0_rd0_suppressed", s_rdu, 0);
        chk("pre_rst_addr", BRAM_ADDR, 120);

        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs()), 0);
        chk("async_rst_cnt", PKT_CNT, 0);
        @(negedge CLK320);
        repeat (2) tick();
        @(negedge CLK320);
        RST_N = 1'b1;
        tick();
        chk("restart_start", PKT_START, 1);
        chk("restart_addr", BRAM_ADDR, 0);
        chk("restart_rd0", RD_EN_0, 0);
        tick();
        chk("restart_wr0", WR_EN_0, 1);
        chk("restart_addr1", BRAM_ADDR, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
